// File: rtl/param_mux_scanner.sv
// Registered NCH-to-1 channel mux with manual select and round-robin auto-scan.
// Define MUX_MASK_EN to add the ch_mask_i port that restricts which channels the scan visits.
module param_mux_scanner #(
    parameter int NCH     = 7,
    parameter int W       = 1,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clock_i,
    input  logic               resetn_i,
    input  logic [NCH*W-1:0]   data_in_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               hold_i,
`ifdef MUX_MASK_EN
    input  logic [NCH-1:0]     ch_mask_i,
`endif
    output logic [W-1:0]       out_o,
    output logic [SEL_W-1:0]   cur_ch_o,
    output logic               sel_err_o,
    output logic               switch_pulse_o
);

    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_e;

    localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NCH);

    state_e                   state_q;
    logic [SEL_W-1:0]         cur_ch_q, next_ch_d, adv_ch;
    logic [DWELL_W-1:0]       dwell_cnt_q, dwell_cnt_d, dwell_last;
    logic [W-1:0]             out_q;
    logic                     sel_err_q, sel_err_d, switch_pulse_q;
    logic                     adv_found;
    logic [NCH-1:0]           scan_mask;
    logic [NCH-1:0][W-1:0]    ch_data;

    assign ch_data = data_in_i;

`ifdef MUX_MASK_EN
    assign scan_mask = ch_mask_i;
`else
    assign scan_mask = '1;
`endif

    // dwell of 0 behaves as 1, so the last count index is dwell-1 clamped at 0
    assign dwell_last = (dwell_i == '0) ? '0 : dwell_i - 1'b1;

    // First enabled channel above cur_ch, searching upward with wrap (cur_ch itself excluded)
    always_comb begin : adv_search
        logic [SEL_W:0] c;
        c         = '0;
        adv_found = 1'b0;
        adv_ch    = cur_ch_q;
        for (int i = 1; i < NCH; i++) begin
            c = {1'b0, cur_ch_q} + (SEL_W+1)'(i);
            if (c >= NCH_L) c = c - NCH_L;
            if (!adv_found && scan_mask[c[SEL_W-1:0]]) begin
                adv_found = 1'b1;
                adv_ch    = c[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        next_ch_d   = cur_ch_q;
        dwell_cnt_d = dwell_cnt_q;
        sel_err_d   = 1'b0;
        if (!mode_i) begin
            dwell_cnt_d = '0;
            if ({1'b0, sel_i} < NCH_L) begin
                next_ch_d = sel_i;
            end else begin
                next_ch_d = '0;
                sel_err_d = 1'b1;
            end
        end else if (state_q == MANUAL) begin
            // scan entry: stay on the current channel, restart the dwell count
            dwell_cnt_d = '0;
        end else if (!hold_i) begin
            if (dwell_cnt_q >= dwell_last) begin
                if (adv_found) begin
                    next_ch_d   = adv_ch;
                    dwell_cnt_d = '0;
                end else if (scan_mask[cur_ch_q]) begin
                    dwell_cnt_d = '0;
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q        <= MANUAL;
            cur_ch_q       <= '0;
            dwell_cnt_q    <= '0;
            out_q          <= '0;
            sel_err_q      <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= mode_i ? SCAN : MANUAL;
            cur_ch_q       <= next_ch_d;
            dwell_cnt_q    <= dwell_cnt_d;
            out_q          <= ch_data[next_ch_d];
            sel_err_q      <= sel_err_d;
            switch_pulse_q <= (next_ch_d != cur_ch_q);
        end
    end

    assign out_o          = out_q;
    assign cur_ch_o       = cur_ch_q;
    assign sel_err_o      = sel_err_q;
    assign switch_pulse_o = switch_pulse_q;

endmodule

// File: tb/tb_param_mux_scanner.sv
// Directed bench for param_mux_scanner (NCH=7, W=4): manual select, range error,
// auto-scan dwell/wrap, hold/mode interplay, mid-scan reset and optional scan mask.
module tb_param_mux_scanner;
    localparam int NCH = 7, W = 4, SEL_W = 3, DWELL_W = 8;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NCH*W-1:0]   data_in;
    logic [SEL_W-1:0]   sel;
    logic               mode, hold;
    logic [DWELL_W-1:0] dwell;
    logic [NCH-1:0]     ch_mask;
    logic [W-1:0]       out;
    logic [SEL_W-1:0]   cur_ch;
    logic               sel_err, switch_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_mux_scanner #(.NCH(NCH), .W(W), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clock_i        (clk),
        .resetn_i       (resetn),
        .data_in_i      (data_in),
        .sel_i          (sel),
        .mode_i         (mode),
        .dwell_i        (dwell),
        .hold_i         (hold),
`ifdef MUX_MASK_EN
        .ch_mask_i      (ch_mask),
`endif
        .out_o          (out),
        .cur_ch_o       (cur_ch),
        .sel_err_o      (sel_err),
        .switch_pulse_o (switch_pulse)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // one clock edge; outputs are then sampled 1ns later, inputs may be changed
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int ch, input int o, input int pl);
        chk({tag, ".cur_ch"}, int'(cur_ch), ch);
        chk({tag, ".out"}, int'(out), o);
        chk({tag, ".pulse"}, int'(switch_pulse), pl);
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        data_in[k*W +: W] = v;
    endtask

    initial begin
        logic [NCH-1:0] pat;
        int ch;
        pat = 7'b1010101;
        resetn = 1'b0; mode = 1'b0; sel = '0; hold = 1'b0; dwell = '0; ch_mask = '1;
        data_in = '0;
        for (int k = 0; k < NCH; k++) set_ch(k, {3'b000, pat[k]});

        // reset held two cycles
        for (int r = 0; r < 2; r++) begin
            step();
            chk_st("reset", int'(cur_ch), 0, 0);
            chk("reset.cur_ch0", int'(cur_ch), 0);
            chk("reset.out0", int'(out), 0);
            chk("reset.sel_err", int'(sel_err), 0);
        end

        // manual sweep 0..6: out = 1,0,1,0,1,0,1
        resetn = 1'b1;
        step();
        chk_st("man0", 0, 1, 0);
        for (int s = 1; s < NCH; s++) begin
            sel = SEL_W'(s);
            step();
            chk_st("man", s, (s % 2 == 0) ? 1 : 0, 1);
        end

        // out-of-range select
        sel = 3'd7;
        step();
        chk_st("oor", 0, 1, 1);
        chk("oor.sel_err", int'(sel_err), 1);
        sel = 3'd3;
        step();
        chk_st("oor_clr", 3, 0, 1);
        chk("oor_clr.sel_err", int'(sel_err), 0);

        // auto-scan dwell=3, channel k carries k+1
        for (int k = 0; k < NCH; k++) set_ch(k, 4'(k + 1));
        sel = '0;
        step();
        chk_st("pre_scan", 0, 1, 1);
        mode = 1'b1; dwell = 8'd3;
        step();
        chk_st("scan_entry", 0, 1, 0);
        for (int n = 1; n <= 22; n++) begin
            step();
            ch = (n / 3) % NCH;
            chk_st("scan_d3", ch, ch + 1, (n % 3 == 0) ? 1 : 0);
        end
        // now on channel 0, second cycle; dwell=0 advances every cycle
        dwell = 8'd0;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk_st("scan_d0", n, n + 1, 1);
        end

        // hold on the advance cycle of channel 2
        mode = 1'b0; sel = '0;
        step();
        chk_st("hold_pre", 0, 1, 1);
        mode = 1'b1; dwell = 8'd3;
        step();
        for (int n = 1; n <= 8; n++) step();
        chk_st("hold_at2", 2, 3, 0);
        hold = 1'b1;
        step();
        chk_st("hold1", 2, 3, 0);
        set_ch(2, 4'hA);
        step();
        chk_st("hold_live", 2, 10, 0);
        step();
        chk_st("hold3", 2, 10, 0);
        hold = 1'b0;
        step();
        chk_st("hold_rel", 3, 4, 1);
        hold = 1'b1; mode = 1'b0; sel = 3'd5;
        step();
        chk_st("mode_over_hold", 5, 6, 1);
        chk("mode_over_hold.sel_err", int'(sel_err), 0);

        // reset mid-scan at cur_ch=5, dwell_cnt=1
        hold = 1'b0; mode = 1'b1;
        step();
        chk_st("rst_entry", 5, 6, 0);
        step();
        chk_st("rst_cnt1", 5, 6, 0);
        resetn = 1'b0;
        step();
        chk_st("rst_mid", 0, 0, 0);
        chk("rst_mid.sel_err", int'(sel_err), 0);
        resetn = 1'b1;
        step();
        chk_st("restart0", 0, 1, 0);
        step();
        step();
        chk_st("restart2", 0, 1, 0);
        step();
        chk_st("restart_adv", 1, 2, 1);

`ifdef MUX_MASK_EN
        mode = 1'b0; sel = '0;
        step();
        chk_st("mask_pre", 0, 1, 1);
        ch_mask = 7'b0100101; dwell = 8'd1; mode = 1'b1;
        step();
        chk_st("mask_entry", 0, 1, 0);
        step(); chk_st("mask_v2", 2, 10, 1);
        step(); chk_st("mask_v5", 5, 6, 1);
        step(); chk_st("mask_v0", 0, 1, 1);
        step(); chk_st("mask_v2b", 2, 10, 1);
        ch_mask = '0;
        step(); chk_st("mask_zero1", 2, 10, 0);
        step(); chk_st("mask_zero2", 2, 10, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
